// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side FIFO controller between the serial receiver and
// the CPU bus. It buffers received bytes and serves them through a pop
// handshake. It also tracks overrun and drives a level interrupt.
// Optional feature macro: UART_RX_TIMEOUT_EN. When this macro is defined, the
// design adds the idle timeout counter, the timeout FSM and the timeout flag.
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_en,
  input  logic                          rx_end,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_busy,
  input  logic                          rd_req,
  output logic                          rd_valid,
  output logic [7:0]                    rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          empty,
  output logic                          full,
  input  logic [$clog2(FIFO_DEPTH):0]   thresh,
  input  logic                          irq_en,
  input  logic                          clr_flags,
  output logic                          overrun,
  output logic                          timeout,
  output logic                          irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
  localparam logic [15:0]   IDLE_LAST_C = 16'(TIMEOUT_CYC - 1);

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic [CW-1:0] thr_eff_s;
  logic          empty_r;
  logic          full_r;
  logic          rd_valid_r;
  logic [7:0]    rd_data_r;
  logic          overrun_r;
  logic          irq_r;
  logic          push_s;
  logic          pop_s;
  logic          drop_s;
  logic          level_s;
  logic          timeout_s;

  // A pop on a full FIFO frees the slot that a simultaneous push then uses.
  assign pop_s  = rd_req & ~empty_r;
  assign push_s = rx_end & rx_en & (~full_r | pop_s);
  assign drop_s = rx_end & rx_en & full_r & ~pop_s;

  // Next occupancy: +1 on push only, -1 on pop only.
  always_comb begin
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Threshold of zero behaves as one; level term compares occupancy with it.
  always_comb begin
    thr_eff_s = thresh;
    if (thresh == CW'(0)) begin
      thr_eff_s = CW'(1);
    end else begin
      thr_eff_s = thresh;
    end
    level_s = (count_r >= thr_eff_s);
  end

  // Storage array; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_r[wr_ptr_r] <= rx_data;
    end
  end

  // Pointers, occupancy, status and read port registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= 8'h00;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r  <= rd_ptr_r + AW'(1);
        rd_data_r <= mem_r[rd_ptr_r];
      end
      rd_valid_r <= pop_s;
      count_r    <= count_nxt_s;
      empty_r    <= (count_nxt_s == CW'(0));
      full_r     <= (count_nxt_s == DEPTH_C);
    end
  end

  // Sticky overrun flag; a drop in the same cycle beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_r <= 1'b0;
    end else if (drop_s) begin
      overrun_r <= 1'b1;
    end else if (clr_flags) begin
      overrun_r <= 1'b0;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FIRED = 2'd2
  } state_t;

  state_t      state_r;
  logic [15:0] idle_r;
  logic        timeout_r;
  logic        activity_s;
  logic        fire_s;

  // Idle detection and the timeout firing condition.
  always_comb begin
    activity_s = push_s | pop_s | rx_busy;
    fire_s     = 1'b0;
    if ((state_r == ST_WAIT) && !activity_s && (idle_r == IDLE_LAST_C)) begin
      fire_s = 1'b1;
    end else begin
      fire_s = 1'b0;
    end
  end

  // Timeout FSM with its idle counter; an empty FIFO always forces ST_EMPTY.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_EMPTY;
      idle_r  <= 16'd0;
    end else if (count_nxt_s == CW'(0)) begin
      state_r <= ST_EMPTY;
      idle_r  <= 16'd0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          state_r <= ST_WAIT;
          idle_r  <= 16'd0;
        end
        ST_WAIT: begin
          if (activity_s) begin
            idle_r <= 16'd0;
          end else if (fire_s) begin
            state_r <= ST_FIRED;
            idle_r  <= 16'd0;
          end else begin
            idle_r <= idle_r + 16'd1;
          end
        end
        ST_FIRED: begin
          if (push_s || pop_s) begin
            state_r <= ST_WAIT;
            idle_r  <= 16'd0;
          end
        end
        default: begin
          state_r <= ST_EMPTY;
          idle_r  <= 16'd0;
        end
      endcase
    end
  end

  // Sticky timeout flag; firing in the same cycle beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_r <= 1'b0;
    end else if (fire_s) begin
      timeout_r <= 1'b1;
    end else if (clr_flags) begin
      timeout_r <= 1'b0;
    end
  end

  assign timeout_s = timeout_r;
`else
  logic unused_s;

  assign unused_s  = rx_busy | (|IDLE_LAST_C);
  assign timeout_s = 1'b0;
`endif

  // Registered interrupt level.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_en & (level_s | timeout_s | overrun_r);
    end
  end

  assign rd_valid = rd_valid_r;
  assign rd_data  = rd_data_r;
  assign count    = count_r;
  assign empty    = empty_r;
  assign full     = full_r;
  assign overrun  = overrun_r;
  assign timeout  = timeout_s;
  assign irq      = irq_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: vector table plus hand-written
// sequences; popped bytes are checked against a reference-model scoreboard.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 16;
  localparam int TCYC  = 8;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_en;
  logic          rx_end;
  logic [7:0]    rx_data;
  logic          rx_busy;
  logic          rd_req;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic [CW-1:0] thresh;
  logic          irq_en;
  logic          clr_flags;
  logic          overrun;
  logic          timeout;
  logic          irq;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_q[$];    // reference FIFO contents
  logic [7:0] exp_q[$];  // bytes expected on the read port, in order

  typedef struct {
    logic          en;
    logic          e;
    logic [7:0]    d;
    logic          r;
    logic [CW-1:0] cnt;
    logic          emp;
    logic          ful;
    logic [7:0]    rdd;
  } vec_t;

  vec_t vt[8];

  uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .reset(reset), .rx_en(rx_en), .rx_end(rx_end),
    .rx_data(rx_data), .rx_busy(rx_busy), .rd_req(rd_req),
    .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
    .empty(empty), .full(full), .thresh(thresh), .irq_en(irq_en),
    .clr_flags(clr_flags), .overrun(overrun), .timeout(timeout), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; the reference model predicts pushes and pops.
  task automatic cyc(input logic e, input logic [7:0] d, input logic r);
    logic m_pop;
    logic m_push;
    rx_end  = e;
    rx_data = d;
    rd_req  = r;
    m_pop   = r && (m_q.size() > 0);
    m_push  = e && rx_en && ((m_q.size() < DEPTH) || m_pop);
    if (m_pop) exp_q.push_back(m_q.pop_front());
    if (m_push) m_q.push_back(d);
    tick;
    rx_end = 1'b0;
    rd_req = 1'b0;
  endtask

  // Scoreboard: every read pulse must match the next expected byte.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_valid: unexpected pulse with data %0h", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %0h, expected %0h", rd_data, e);
        end
      end
    end
  end

  initial begin
    //           en    e     d      r     cnt    emp   ful   rdd
    vt[0] = '{1'b1, 1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 1'b0, 8'h00};
    vt[1] = '{1'b1, 1'b1, 8'h3C, 1'b0, 5'd2, 1'b0, 1'b0, 8'h00};
    vt[2] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 8'hA5};
    vt[3] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'h3C};
    vt[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'h3C};
    vt[5] = '{1'b0, 1'b1, 8'h99, 1'b0, 5'd0, 1'b1, 1'b0, 8'h3C};
    vt[6] = '{1'b1, 1'b1, 8'h11, 1'b1, 5'd1, 1'b0, 1'b0, 8'h3C};
    vt[7] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'h11};

    reset = 1'b1; rx_en = 1'b1; rx_end = 1'b0; rx_data = 8'h00; rx_busy = 1'b0;
    rd_req = 1'b0; thresh = 5'd4; irq_en = 1'b0; clr_flags = 1'b0;
    tick; tick;
    chk("reset count", count, 5'd0);
    chk("reset empty", empty, 1'b1);
    chk("reset full", full, 1'b0);
    chk("reset rd_valid", rd_valid, 1'b0);
    chk("reset rd_data", rd_data, 8'h00);
    chk("reset overrun", overrun, 1'b0);
    chk("reset timeout", timeout, 1'b0);
    chk("reset irq", irq, 1'b0);
    reset = 1'b0;

    // Basic push/pop, empty pop, rx_en gating, push+pop on empty.
    for (int i = 0; i < 8; i++) begin
      rx_en = vt[i].en;
      cyc(vt[i].e, vt[i].d, vt[i].r);
      chk($sformatf("vec%0d count", i), count, vt[i].cnt);
      chk($sformatf("vec%0d empty", i), empty, vt[i].emp);
      chk($sformatf("vec%0d full", i), full, vt[i].ful);
      chk($sformatf("vec%0d rd_data", i), rd_data, vt[i].rdd);
    end
    rx_en = 1'b1;

    // Fill, overflow, clear/set collision, clear, gated pulses.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0);
    chk("fill count", count, 5'd16);
    chk("fill full", full, 1'b1);
    chk("fill overrun", overrun, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0);
    chk("drop count", count, 5'd16);
    chk("drop overrun", overrun, 1'b1);
    clr_flags = 1'b1;
    cyc(1'b1, 8'hFE, 1'b0);
    clr_flags = 1'b0;
    chk("set beats clear overrun", overrun, 1'b1);
    clr_flags = 1'b1;
    tick;
    clr_flags = 1'b0;
    chk("clr overrun", overrun, 1'b0);
    rx_en = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hDD, 1'b0);
    chk("gated count", count, 5'd16);
    chk("gated overrun", overrun, 1'b0);
    rx_en = 1'b1;
    cyc(1'b1, 8'hEE, 1'b1);
    chk("full push+pop count", count, 5'd16);
    chk("full push+pop overrun", overrun, 1'b0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 8'h00, 1'b1);
    tick;
    chk("drain empty", empty, 1'b1);
    chk("drain count", count, 5'd0);

    // Threshold interrupt timing.
    irq_en = 1'b1; thresh = 5'd4;
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h20 + 8'(i), 1'b0);
    tick; tick;
    chk("irq below thresh", irq, 1'b0);
    cyc(1'b1, 8'h23, 1'b0);
    chk("irq N+1", irq, 1'b0);
    tick;
    chk("irq N+2", irq, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    tick;
    chk("irq after pop", irq, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
    thresh = 5'd0;
    cyc(1'b1, 8'h30, 1'b0);
    tick;
    chk("irq thresh0", irq, 1'b1);
    irq_en = 1'b0;
    cyc(1'b0, 8'h00, 1'b1);
    thresh = 5'd4;
    tick;

`ifdef UART_RX_TIMEOUT_EN
    cyc(1'b1, 8'h51, 1'b0);
    repeat (7) tick;
    chk("timeout early", timeout, 1'b0);
    tick;
    chk("timeout fire", timeout, 1'b1);
    clr_flags = 1'b1;
    tick;
    clr_flags = 1'b0;
    chk("timeout clr", timeout, 1'b0);
    cyc(1'b1, 8'h52, 1'b0);
    repeat (3) tick;
    rx_busy = 1'b1;
    repeat (2) tick;
    rx_busy = 1'b0;
    repeat (7) tick;
    chk("timeout delayed early", timeout, 1'b0);
    tick;
    chk("timeout delayed fire", timeout, 1'b1);
    clr_flags = 1'b1;
    tick;
    clr_flags = 1'b0;
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
`else
    cyc(1'b1, 8'h51, 1'b0);
    repeat (20) tick;
    chk("timeout disabled", timeout, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
`endif
    tick;

    // Reset in the middle of a drain.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    reset = 1'b1;
    rd_req = 1'b1;
    tick;
    reset = 1'b0;
    rd_req = 1'b0;
    m_q.delete();
    chk("mid reset count", count, 5'd0);
    chk("mid reset empty", empty, 1'b1);
    chk("mid reset rd_valid", rd_valid, 1'b0);
    chk("mid reset rd_data", rd_data, 8'h00);
    cyc(1'b1, 8'h77, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    tick; tick;
    chk("scoreboard drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
